// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the main-memory port arbiter.
// State encodings, default error word and counter sizing helper.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_BUSY    = 2'd1,
      ARB_RELEASE = 2'd2
   } arb_state_t;

   localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Saturating transaction watchdog: counts enabled cycles, flags the
// last allowed cycle. LIMIT of 0 disables the expire output.
module arb_timeout_counter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam int W = cnt_width(int'(LIMIT));
   localparam logic [W-1:0] MAX  = '1;
   localparam logic [W-1:0] LAST = (LIMIT == 0) ? '0 : W'(LIMIT - 1);
   localparam logic         ON   = (LIMIT != 0);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && cnt_q != MAX) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expire = ON & en & (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master, one-slave arbiter for the main-memory port with
// round-robin/fixed priority and a hung-transaction watchdog.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned PRIO_MODE      = 0,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] m0_a,
   input  logic [31:0] m0_d,
   input  logic        m0_we,
   input  logic        m0_rd,
   output logic [31:0] m0_spo,
   output logic        m0_ready,
   input  logic [31:0] m1_a,
   input  logic [31:0] m1_d,
   input  logic        m1_we,
   input  logic        m1_rd,
   output logic [31:0] m1_spo,
   output logic        m1_ready,
   output logic [31:0] s_a,
   output logic [31:0] s_d,
   output logic        s_we,
   output logic        s_rd,
   input  logic [31:0] s_spo,
   input  logic        s_ready,
   output logic [1:0]  grant,
   output logic        err_timeout,
   output logic [31:0] err_addr
);

   arb_state_t  state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic        last_q, last_d;
   logic [31:0] err_addr_q, err_addr_d;

   logic        req0, req1, busy, sel1;
   logic [31:0] g_a, g_d;
   logic        g_we, g_rd, g_req;
   logic        expire, done, tmo, win1;

   assign req0 = m0_rd | m0_we;
   assign req1 = m1_rd | m1_we;
   assign busy = (state_q == ARB_BUSY);
   assign sel1 = grant_q[1];

   assign g_a   = sel1 ? m1_a  : m0_a;
   assign g_d   = sel1 ? m1_d  : m0_d;
   assign g_we  = sel1 ? m1_we : m0_we;
   assign g_rd  = sel1 ? m1_rd : m0_rd;
   assign g_req = g_we | g_rd;

   arb_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (busy),
      .clr    (!busy),
      .expire (expire)
   );

   // A slave ready on the expiry cycle is a normal completion.
   assign done = busy & s_ready;
   assign tmo  = busy & expire & ~s_ready & g_req;

   // last_q = 1 means m1 owned the bus last, so m0 wins a tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         grant_q    <= 2'b00;
         last_q     <= 1'b1;
         err_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         err_addr_q <= err_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      err_addr_d = err_addr_q;
      win1       = 1'b0;
      unique case (state_q)
         ARB_IDLE: begin
            if (req0 && req1) begin
               win1 = (PRIO_MODE == 0) && !last_q;
            end else begin
               win1 = req1;
            end
            if (req0 || req1) begin
               state_d = ARB_BUSY;
               grant_d = win1 ? 2'b10 : 2'b01;
            end
         end
         ARB_BUSY: begin
            if (done) begin
               state_d = ARB_RELEASE;
               grant_d = 2'b00;
               last_d  = sel1;
            end else if (tmo) begin
               state_d    = ARB_RELEASE;
               grant_d    = 2'b00;
               err_addr_d = g_a;
            end else if (!g_req) begin
               state_d = ARB_RELEASE;
               grant_d = 2'b00;
            end
         end
         ARB_RELEASE: begin
            state_d = ARB_IDLE;
            grant_d = 2'b00;
         end
         default: begin
            state_d = ARB_IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   always_comb begin
      s_a      = '0;
      s_d      = '0;
      s_we     = 1'b0;
      s_rd     = 1'b0;
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_spo   = '0;
      m1_spo   = '0;
      if (busy) begin
         s_a      = g_a;
         s_d      = g_d;
         s_we     = g_we;
         s_rd     = g_rd & ~g_we;
         m0_ready = grant_q[0] & (done | tmo);
         m1_ready = grant_q[1] & (done | tmo);
         if (m0_ready) m0_spo = done ? s_spo : ERR_DATA;
         if (m1_ready) m1_spo = done ? s_spo : ERR_DATA;
      end
   end

   assign grant       = grant_q;
   assign err_timeout = tmo;
   assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus
// randomized transactions against a transaction-level model.
module tb_mem_arbiter;

   localparam int TMO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] ma [2];
   logic [31:0] md [2];
   logic        mwe [2];
   logic        mrd [2];
   logic [31:0] s_spo;
   logic        s_ready;

   logic [31:0] spo0, spo1, s_a, s_d, err_addr;
   logic        rdy0, rdy1, s_we, s_rd, err_to;
   logic [1:0]  grant;

   mem_arbiter #(
      .PRIO_MODE      (0),
      .TIMEOUT_CYCLES (TMO),
      .ERR_DATA       (32'hDEADBEEF)
   ) dut0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .m0_a        (ma[0]),
      .m0_d        (md[0]),
      .m0_we       (mwe[0]),
      .m0_rd       (mrd[0]),
      .m0_spo      (spo0),
      .m0_ready    (rdy0),
      .m1_a        (ma[1]),
      .m1_d        (md[1]),
      .m1_we       (mwe[1]),
      .m1_rd       (mrd[1]),
      .m1_spo      (spo1),
      .m1_ready    (rdy1),
      .s_a         (s_a),
      .s_d         (s_d),
      .s_we        (s_we),
      .s_rd        (s_rd),
      .s_spo       (s_spo),
      .s_ready     (s_ready),
      .grant       (grant),
      .err_timeout (err_to),
      .err_addr    (err_addr)
   );

   // Fixed-priority instance with an always-ready slave.
   logic        p_rd0 = 1'b0;
   logic        p_rd1 = 1'b0;
   logic [31:0] p_spo0, p_spo1, p_s_a, p_s_d, p_err_addr;
   logic        p_rdy0, p_rdy1, p_s_we, p_s_rd, p_err_to;
   logic [1:0]  p_grant;

   mem_arbiter #(
      .PRIO_MODE      (1),
      .TIMEOUT_CYCLES (TMO),
      .ERR_DATA       (32'hDEADBEEF)
   ) dut1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .m0_a        (32'h0000_0100),
      .m0_d        (32'h0),
      .m0_we       (1'b0),
      .m0_rd       (p_rd0),
      .m0_spo      (p_spo0),
      .m0_ready    (p_rdy0),
      .m1_a        (32'h0000_0200),
      .m1_d        (32'h0),
      .m1_we       (1'b0),
      .m1_rd       (p_rd1),
      .m1_spo      (p_spo1),
      .m1_ready    (p_rdy1),
      .s_a         (p_s_a),
      .s_d         (p_s_d),
      .s_we        (p_s_we),
      .s_rd        (p_s_rd),
      .s_spo       (32'h5555_0000),
      .s_ready     (p_s_rd | p_s_we),
      .grant       (p_grant),
      .err_timeout (p_err_to),
      .err_addr    (p_err_addr)
   );

   int tests = 0;
   int fails = 0;

   bit pend [2];
   bit last_owner = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int m);
      int kind;
      kind   = $urandom_range(0, 2);
      ma[m]  = 32'h2000_0000 | ($urandom & 32'h0000_FFFC);
      md[m]  = $urandom;
      mrd[m] = (kind != 1);
      mwe[m] = (kind != 0);
      pend[m] = 1'b1;
   endtask

   function automatic int model_pick();
      if (pend[0] && pend[1]) return last_owner ? 0 : 1;
      return pend[1] ? 1 : 0;
   endfunction

   // mode: 0 none, 1 random late request, 2 directed m1 write
   task automatic run_txn(input int lat, input logic [31:0] data,
                          input int exp_wait, input int mode);
      int g, o, waited, c;
      bit got, timed, fin;
      logic [31:0] exp_spo, gspo, ospo;
      logic grdy, ordy;
      g = model_pick();
      o = 1 - g;
      got = 0;
      waited = 0;
      for (int i = 0; i < 6 && !got; i++) begin
         tick();
         waited++;
         if (grant != 2'b00) got = 1;
      end
      chk("grant", {30'b0, grant}, (g == 0) ? 32'd1 : 32'd2);
      chk("grant_latency", waited, exp_wait);
      fin = 0;
      timed = 0;
      c = 1;
      while (!fin) begin
         s_ready = (c == lat);
         s_spo   = (c == lat) ? data : $urandom;
         if (c == 2 && !pend[o] && mode == 1 && $urandom_range(0, 1) == 1)
            set_req(o);
         if (c == 2 && mode == 2) begin
            ma[1] = 32'h2000_0400;
            md[1] = 32'hA5A5_A5A5;
            mwe[1] = 1'b1;
            mrd[1] = 1'b0;
            pend[1] = 1'b1;
         end
         #2;
         grdy = (g == 1) ? rdy1 : rdy0;
         ordy = (g == 1) ? rdy0 : rdy1;
         gspo = (g == 1) ? spo1 : spo0;
         ospo = (g == 1) ? spo0 : spo1;
         chk("s_a", s_a, ma[g]);
         chk("s_d", s_d, md[g]);
         chk("s_strobe", {30'b0, s_we, s_rd},
             {30'b0, mwe[g], mrd[g] & ~mwe[g]});
         chk("other_idle", {ordy, ospo}, 33'b0);
         if (c == lat || c == TMO) begin
            timed   = (c != lat);
            exp_spo = timed ? 32'hDEADBEEF : data;
            chk("m_ready", grdy, 1);
            chk("m_spo", gspo, exp_spo);
            chk("err_timeout", err_to, timed);
            fin = 1;
         end else begin
            chk("m_ready_early", {grdy, gspo}, 33'b0);
            chk("err_quiet", err_to, 0);
            tick();
            c++;
         end
      end
      tick();
      s_ready = 1'b0;
      if (timed) chk("err_addr", err_addr, ma[g]);
      else last_owner = g[0];
      mrd[g] = 1'b0;
      mwe[g] = 1'b0;
      pend[g] = 1'b0;
      #1;
      chk("release", {29'b0, grant, s_we | s_rd}, 32'b0);
   endtask

   initial begin
      int nb;
      for (int m = 0; m < 2; m++) begin
         ma[m] = '0; md[m] = '0; mwe[m] = 0; mrd[m] = 0; pend[m] = 0;
      end
      s_spo = '0;
      s_ready = 1'b0;
      #12;
      chk("rst_grant", {30'b0, grant}, 0);
      chk("rst_slave", {s_a | s_d, s_we, s_rd}, 34'b0);
      chk("rst_master", {spo0 | spo1, rdy0, rdy1}, 34'b0);
      chk("rst_err", {err_addr, err_to}, 33'b0);
      tick();
      rst_n = 1'b1;
      tick();

      // m0 read alone; m1 write raised mid-transaction
      ma[0] = 32'h2000_0010; md[0] = '0; mrd[0] = 1; mwe[0] = 0;
      pend[0] = 1;
      run_txn(4, 32'h1234_5678, 1, 2);
      run_txn(2, 32'h0, 2, 0);

      // timeout
      ma[0] = 32'h2000_0040; mrd[0] = 1; mwe[0] = 0; pend[0] = 1;
      run_txn(20, 32'h0, 2, 0);

      // ready exactly on the timeout cycle
      set_req(0);
      set_req(1);
      run_txn(TMO, 32'hCAFE_F00D, 2, 0);

      // ties
      for (int k = 0; k < 4; k++) begin
         if (!pend[0]) set_req(0);
         if (!pend[1]) set_req(1);
         run_txn($urandom_range(1, 6), $urandom, 2, 0);
      end

      // random traffic
      for (int k = 0; k < 40; k++) begin
         if (!pend[0] && $urandom_range(0, 1) == 1) set_req(0);
         if (!pend[1] && $urandom_range(0, 1) == 1) set_req(1);
         if (!pend[0] && !pend[1]) set_req($urandom_range(0, 1));
         run_txn($urandom_range(1, 11), $urandom, 2, 1);
      end
      for (int m = 0; m < 2; m++) begin
         mrd[m] = 0; mwe[m] = 0; pend[m] = 0;
      end

      // fixed priority: m0 always wins while it keeps requesting
      p_rd0 = 1'b1;
      p_rd1 = 1'b1;
      nb = 0;
      for (int k = 0; k < 24; k++) begin
         tick();
         #2;
         if (p_grant != 2'b00) begin
            nb++;
            chk("prio_grant", {30'b0, p_grant}, 32'd1);
         end
      end
      chk("prio_count", nb, 8);
      p_rd0 = 1'b0;
      p_rd1 = 1'b0;
      tick();
      tick();

      // asynchronous reset in the middle of BUSY
      ma[0] = 32'h2000_0080; mrd[0] = 1; mwe[0] = 0;
      tick();
      tick();
      chk("pre_rst_busy", {s_rd, grant}, 3'b101);
      s_ready = 1'b1;
      s_spo = 32'h7777_7777;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_strobe", {s_rd, s_we, grant}, 4'b0);
      chk("mid_rst_ready", {rdy0, rdy1}, 2'b0);
      s_ready = 1'b0;
      mrd[0] = 0;
      tick();
      rst_n = 1'b1;
      last_owner = 1'b1;
      set_req(0);
      set_req(1);
      run_txn(2, 32'h0BAD_CAFE, 1, 0);
      mrd[1] = 0; mwe[1] = 0; pend[1] = 0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
